// File: rtl/trace_pkg.sv
// Shared types and helpers for the debug-trace UART transmitter.
package trace_pkg;

   // Serialiser states for one UART 8N1 character.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

   localparam int         FRAME_BYTES       = 14;
   localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

   // One captured CPU observation.
   typedef struct packed {
      logic [4:0]  regin;
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] regout;
   } snapshot_t;

   // Maps a frame byte index to the byte sent on the wire (multi-byte fields big-endian).
   function automatic logic [7:0] frame_byte(input logic [3:0] idx,
                                             input logic [7:0] sync,
                                             input snapshot_t  snap);
      logic [7:0] b;
      case (idx)
         4'd0:    b = sync;
         4'd1:    b = {3'b000, snap.regin};
         4'd2:    b = snap.pc[31:24];
         4'd3:    b = snap.pc[23:16];
         4'd4:    b = snap.pc[15:8];
         4'd5:    b = snap.pc[7:0];
         4'd6:    b = snap.instr[31:24];
         4'd7:    b = snap.instr[23:16];
         4'd8:    b = snap.instr[15:8];
         4'd9:    b = snap.instr[7:0];
         4'd10:   b = snap.regout[31:24];
         4'd11:   b = snap.regout[23:16];
         4'd12:   b = snap.regout[15:8];
         4'd13:   b = snap.regout[7:0];
         default: b = 8'h00;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// UART 8N1 character serialiser. A new character may be started in the
// last cycle of the previous stop bit so characters run back-to-back.
module uart_tx_byte
   import trace_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       CLOCK,
   input  logic       Reset,
   input  logic       start,
   input  logic [7:0] byte_in,
   output logic       ready,
   output logic       idle,
   output logic       tx
);

   localparam int            BW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

   tx_state_t     state_q, state_d;
   logic [BW-1:0] baud_q, baud_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          tx_q, tx_d;

   assign idle  = (state_q == IDLE);
   assign ready = idle || ((state_q == STOP) && (baud_q == '0));
   assign tx    = tx_q;

   // State, counters and line register; the line idles high out of reset.
   always_ff @(posedge CLOCK or negedge Reset) begin
      if (!Reset) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
      end
   end

   // Next state: count down each bit, advance on the bit boundary, reload the counter.
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      if (start && ready) begin
         state_d = START;
         baud_d  = BAUD_MAX;
         bit_d   = '0;
         shift_d = byte_in;
         tx_d    = 1'b0;
      end else if ((state_q != IDLE) && (baud_q != '0)) begin
         baud_d = baud_q - 1'b1;
      end else begin
         case (state_q)
            START: begin
               state_d = DATA;
               baud_d  = BAUD_MAX;
               bit_d   = '0;
               tx_d    = shift_q[0];
               shift_d = {1'b0, shift_q[7:1]};
            end
            DATA: begin
               baud_d = BAUD_MAX;
               if (bit_q == 3'd7) begin
                  state_d = STOP;
                  tx_d    = 1'b1;
               end else begin
                  bit_d   = bit_q + 3'd1;
                  tx_d    = shift_q[0];
                  shift_d = {1'b0, shift_q[7:1]};
               end
            end
            STOP: begin
               state_d = IDLE;
               tx_d    = 1'b1;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

endmodule

// File: rtl/trace_uart_tx.sv
// Debug-trace consumer: captures the CPU observation bus on each falling
// edge of the divided CPU clock and streams it as a 14-byte UART frame.
module trace_uart_tx
   import trace_pkg::*;
#(
   parameter int         CLKS_PER_BIT = 434,
   parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE
) (
   input  logic        CLOCK,
   input  logic        Reset,
   input  logic        Enable,
   input  logic        ClockDIV,
   input  logic [4:0]  Regin,
   input  logic [31:0] PC,
   input  logic [31:0] Instr,
   input  logic [31:0] Regout,
   output logic        Tx,
   output logic        Busy,
   output logic [7:0]  Dropped
);

   localparam logic [3:0] LAST_BYTE = 4'(FRAME_BYTES - 1);

   logic       div_q;
   logic       cap_event;
   logic       accept;
   logic       next_byte;
   logic       tx_start;
   logic [7:0] tx_byte;
   logic       tx_ready;
   logic       tx_idle;
   snapshot_t  snap_q;
   logic [3:0] byte_idx_q;
   logic [7:0] dropped_q;

   // Falling edge of the CPU clock: mid CPU cycle, so the observed bus is settled.
   assign cap_event = div_q && !ClockDIV;
   assign accept    = cap_event && Enable && tx_idle;
   // Serialiser is in its final stop-bit cycle and more bytes remain.
   assign next_byte = !tx_idle && tx_ready && (byte_idx_q < LAST_BYTE);
   assign tx_start  = accept || next_byte;
   // The sync byte is a constant, so the first byte does not wait for the snapshot.
   assign tx_byte   = accept ? SYNC_BYTE : frame_byte(byte_idx_q + 4'd1, SYNC_BYTE, snap_q);

   assign Busy    = !tx_idle;
   assign Dropped = dropped_q;

   // One-cycle history of the divided clock for edge detection.
   always_ff @(posedge CLOCK or negedge Reset) begin
      if (!Reset) div_q <= 1'b0;
      else        div_q <= ClockDIV;
   end

   // Snapshot is frozen for the whole frame; only an accepted event reloads it.
   always_ff @(posedge CLOCK or negedge Reset) begin
      if (!Reset)      snap_q <= '0;
      else if (accept) snap_q <= '{regin: Regin, pc: PC, instr: Instr, regout: Regout};
   end

   // Index of the byte currently on the wire.
   always_ff @(posedge CLOCK or negedge Reset) begin
      if (!Reset)         byte_idx_q <= '0;
      else if (accept)    byte_idx_q <= '0;
      else if (next_byte) byte_idx_q <= byte_idx_q + 4'd1;
   end

   // Saturating count of enabled events that arrive while a frame is still going out.
   always_ff @(posedge CLOCK or negedge Reset) begin
      if (!Reset)
         dropped_q <= '0;
      else if (cap_event && Enable && !tx_idle && (dropped_q != 8'hFF))
         dropped_q <= dropped_q + 8'd1;
   end

   uart_tx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_tx (
      .CLOCK  (CLOCK),
      .Reset  (Reset),
      .start  (tx_start),
      .byte_in(tx_byte),
      .ready  (tx_ready),
      .idle   (tx_idle),
      .tx     (Tx)
   );

endmodule

// File: tb/tb_trace_uart_tx.sv
// Bench for trace_uart_tx: directed sequence with random snapshots and a
// frame-level reference model of the expected UART waveform and drop count.
module tb_trace_uart_tx;

   localparam int CPB       = 4;
   localparam int BYTE_CYC  = 10 * CPB;
   localparam int FRAME_CYC = 14 * BYTE_CYC;

   logic        CLOCK = 1'b0;
   logic        Reset;
   logic        Enable;
   logic        ClockDIV;
   logic [4:0]  Regin;
   logic [31:0] PC;
   logic [31:0] Instr;
   logic [31:0] Regout;
   logic        Tx;
   logic        Busy;
   logic [7:0]  Dropped;

   int         n_run    = 0;
   int         n_fail   = 0;
   int         exp_drop = 0;
   logic [7:0] exp_bytes [14];

   always #5 CLOCK = ~CLOCK;

   trace_uart_tx #(
      .CLKS_PER_BIT(CPB),
      .SYNC_BYTE   (8'hA5)
   ) dut (
      .CLOCK   (CLOCK),
      .Reset   (Reset),
      .Enable  (Enable),
      .ClockDIV(ClockDIV),
      .Regin   (Regin),
      .PC      (PC),
      .Instr   (Instr),
      .Regout  (Regout),
      .Tx      (Tx),
      .Busy    (Busy),
      .Dropped (Dropped)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_run++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLOCK);
      #1;
   endtask

   // Drive inputs and build the frame the host should receive.
   task automatic set_snapshot(input logic [4:0] r, input logic [31:0] p,
                               input logic [31:0] i, input logic [31:0] o);
      Regin  = r;
      PC     = p;
      Instr  = i;
      Regout = o;
      exp_bytes[0] = 8'hA5;
      exp_bytes[1] = {3'b000, r};
      for (int k = 0; k < 4; k++) begin
         exp_bytes[2 + k]  = 8'(p >> (24 - 8 * k));
         exp_bytes[6 + k]  = 8'(i >> (24 - 8 * k));
         exp_bytes[10 + k] = 8'(o >> (24 - 8 * k));
      end
   endtask

   task automatic set_random_snapshot();
      set_snapshot(5'($urandom), $urandom, $urandom, $urandom);
   endtask

   // Change ClockDIV while a frame is in progress; an enabled fall counts as a drop.
   task automatic drive_div(input logic v);
      if (ClockDIV === 1'b1 && v === 1'b0 && Enable === 1'b1 && exp_drop < 255)
         exp_drop++;
      ClockDIV = v;
   endtask

   // Produce one accepted CPU-clock fall while idle; returns in the first frame cycle.
   task automatic fall();
      ClockDIV = 1'b1;
      tick();
      ClockDIV = 1'b0;
      tick();
   endtask

   // Check a whole frame starting at its first cycle.
   // mode 0 quiet, 1 div-by-4 + random bus, 2 event in last stop cycle,
   // 3 arm an event for the first idle cycle, 4 Enable drops mid-frame,
   // 5 reset pulse during data bit 3 of byte 6.
   task automatic check_frame(input int mode, input string tag);
      logic [7:0] fb [14];
      logic [7:0] rx [14];
      int         wave_err;
      int         busy_cnt;
      int         b;
      int         k;
      logic       e;
      fb       = exp_bytes;
      wave_err = 0;
      busy_cnt = 0;
      for (int c = 0; c < FRAME_CYC; c++) begin
         b = c / BYTE_CYC;
         k = (c % BYTE_CYC) / CPB;
         e = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : fb[b][k-1];
         if (mode == 5 && c == (6 * 10 + 1 + 3) * CPB + 1) begin
            Reset = 1'b0;
            #1;
            exp_drop = 0;
            chk($sformatf("%s.tx_async", tag), 32'(Tx), 32'd1);
            chk($sformatf("%s.busy_async", tag), 32'(Busy), 32'd0);
            chk($sformatf("%s.dropped_async", tag), 32'(Dropped), 32'(exp_drop));
            return;
         end
         if (Tx !== e) wave_err++;
         if (Busy === 1'b1) busy_cnt++;
         if (k >= 1 && k <= 8 && (c % CPB) == CPB / 2) rx[b][k-1] = Tx;
         case (mode)
            1: begin
               Regin  = 5'($urandom);
               PC     = $urandom;
               Instr  = $urandom;
               Regout = $urandom;
               drive_div(((c / 2) % 2) == 1);
            end
            2: begin
               if (c == FRAME_CYC - 2) drive_div(1'b1);
               else if (c == FRAME_CYC - 1) drive_div(1'b0);
            end
            3: begin
               if (c == 300) set_random_snapshot();
               if (c == FRAME_CYC - 1) drive_div(1'b1);
            end
            4: begin
               if (c == 200) Enable = 1'b0;
               drive_div(((c / 2) % 2) == 1);
            end
            default: ;
         endcase
         tick();
      end
      chk($sformatf("%s.wave_err", tag), 32'(wave_err), 32'd0);
      chk($sformatf("%s.busy_cycles", tag), 32'(busy_cnt), 32'(FRAME_CYC));
      chk($sformatf("%s.busy_end", tag), 32'(Busy), 32'd0);
      chk($sformatf("%s.tx_end", tag), 32'(Tx), 32'd1);
      for (int j = 0; j < 14; j++)
         chk($sformatf("%s.byte%0d", tag, j), 32'(rx[j]), 32'(fb[j]));
      chk($sformatf("%s.dropped", tag), 32'(Dropped), 32'(exp_drop));
   endtask

   initial begin
      int busy_seen;
      Reset    = 1'b0;
      Enable   = 1'b0;
      ClockDIV = 1'b0;
      Regin    = '0;
      PC       = '0;
      Instr    = '0;
      Regout   = '0;

      // Reset held with the CPU clock toggling.
      for (int i = 0; i < 3; i++) begin
         ClockDIV = ~ClockDIV;
         tick();
         chk("reset.tx", 32'(Tx), 32'd1);
         chk("reset.busy", 32'(Busy), 32'd0);
         chk("reset.dropped", 32'(Dropped), 32'd0);
      end
      Reset  = 1'b1;
      Enable = 1'b1;

      // Known snapshot: A5 05 00 40 00 10 00 A3 02 93 00 00 00 2A.
      set_snapshot(5'd5, 32'h0040_0010, 32'h00A3_0293, 32'h0000_002A);
      fall();
      check_frame(0, "fixed");

      for (int n = 0; n < 3; n++) begin
         set_random_snapshot();
         fall();
         check_frame(0, $sformatf("rand%0d", n));
      end

      // Event in the last stop cycle is dropped; event in the first idle cycle is taken.
      set_random_snapshot();
      fall();
      check_frame(2, "last_stop");
      set_random_snapshot();
      fall();
      check_frame(3, "arm_idle");
      ClockDIV = 1'b0;
      tick();
      check_frame(0, "first_idle");

      // Enable drops mid-frame: the frame finishes, later events are ignored.
      set_random_snapshot();
      fall();
      check_frame(4, "enable_off");
      busy_seen = 0;
      for (int c = 0; c < 40; c++) begin
         ClockDIV = ((c / 2) % 2) == 1;
         tick();
         if (Busy !== 1'b0) busy_seen++;
      end
      chk("enable_off.no_frame", 32'(busy_seen), 32'd0);
      chk("enable_off.dropped_hold", 32'(Dropped), 32'(exp_drop));
      Enable = 1'b1;

      // Continuous CPU clock during frames: drops saturate, content is the first snapshot.
      set_random_snapshot();
      fall();
      check_frame(1, "sat1");
      set_random_snapshot();
      fall();
      check_frame(1, "sat2");
      chk("sat.dropped_255", 32'(Dropped), 32'd255);

      // Reset mid-frame, then a fresh complete frame.
      set_random_snapshot();
      fall();
      check_frame(5, "rst_mid");
      tick();
      chk("rst_mid.tx_held", 32'(Tx), 32'd1);
      chk("rst_mid.busy_held", 32'(Busy), 32'd0);
      Reset = 1'b1;
      tick();
      set_random_snapshot();
      fall();
      check_frame(0, "post_rst");

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/trace_uart_tx.md
Name: trace_uart_tx

Overview:
Debug-trace consumer placed beside the single-cycle CPU in the board top level. It samples the CPU's observation outputs (PC, Instr, Regout and the selected register index) once per CPU clock period. It serialises each snapshot as a fixed 14-byte frame on a UART 8N1 line, so a host PC can log execution without a logic analyser. It runs entirely in the fast board-clock domain; the divided CPU clock is treated as a data input.

Parameters:
CLKS_PER_BIT, 434, board-clock cycles per UART bit (50 MHz / 115200); must be >= 2
SYNC_BYTE, 8'hA5, first byte of every frame

Ports:
CLOCK  in  1  board clock; all logic on posedge
Reset  in  1  asynchronous, active-low reset
Enable  in  1  1 = new snapshots may start; 0 = finish current frame, then stay idle
ClockDIV  in  1  divided CPU clock, registered in the CLOCK domain (no synchroniser needed)
Regin  in  5  register index currently routed to Regout
PC  in  32  CPU program counter
Instr  in  32  CPU current instruction
Regout  in  32  contents of register Regin
Tx  out  1  UART serial output; idle high
Busy  out  1  high while a frame is being transmitted
Dropped  out  8  saturating count of capture events lost while Busy

Behaviour:
- Reset (Reset=0, async): Tx=1, Busy=0, Dropped=0, FSM=IDLE, ClockDIV history reg=0, snapshot regs=0.
- Capture event: cycle in which registered ClockDIV history=1 and ClockDIV=0 (falling edge, mid CPU cycle, so PC/Instr/Regout are settled).
- Event && Enable && IDLE: in that same edge, load snapshot {Regin, PC, Instr, Regout}; byte index=0; FSM->START; Busy=1 from the next cycle.
- Event && Enable && not IDLE: Dropped += 1, saturating at 255. Snapshot is untouched.
- Event with Enable=0: ignored, not counted.
- Enable falling mid-frame: the frame completes normally.
- Frame byte order, 14 bytes:
  - SYNC_BYTE
  - {3'b000, Regin}
  - PC[31:24], PC[23:16], PC[15:8], PC[7:0]
  - Instr, big-endian, 4 bytes
  - Regout, big-endian, 4 bytes
- Byte format: start bit 0, data bits LSB first, stop bit 1. Each bit lasts exactly CLKS_PER_BIT cycles. Tx is registered.
- FSM states and transitions:
  - IDLE -> START on accepted event.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA -> STOP after 8 bits.
  - STOP -> START (next byte) if byte index < 13; otherwise STOP -> IDLE.
  - Baud counter counts CLKS_PER_BIT-1 down to 0; it reloads on every bit boundary.
- Timing: Tx first goes 0 one cycle after the accepted event. Busy is high for exactly 140*CLKS_PER_BIT cycles. Consecutive bytes are back-to-back with no idle gap.
- Simultaneous events:
  - Event in the last STOP cycle of byte 13 is counted as dropped (state not yet IDLE).
  - Event in the first IDLE cycle is accepted.
- Reset asserted mid-frame: Tx=1 immediately, frame truncated. A host framing error is acceptable; the host resyncs on SYNC_BYTE.
- Width rules: byte index 4 bits (0..13); bit index 3 bits; baud counter $clog2(CLKS_PER_BIT) bits.

Decomposition:
- Package trace_pkg: state enum {IDLE, START, DATA, STOP}, FRAME_BYTES=14, default SYNC_BYTE, byte-select function mapping index -> snapshot byte.
- One sub-module, uart_tx_byte: start/byte_in/ready handshake, owns baud counter, bit index and Tx register.
- trace_uart_tx owns edge detection, snapshot, byte sequencing and the Dropped counter.

Test Plan (CLKS_PER_BIT=4):
1. Reset=0 for 3 cycles, ClockDIV toggling -> Tx=1, Busy=0, Dropped=0 throughout.
2. Enable=1, Regin=5, PC=0x00400010, Instr=0x00A30293, Regout=0x0000002A, one ClockDIV fall.
   -> Decoded bytes: A5 05 00 40 00 10 00 A3 02 93 00 00 00 2A.
   -> Busy high for exactly 560 cycles; each bit 4 cycles wide.
3. ClockDIV divide-by-4 running continuously during a frame -> Dropped counts every event, saturates at 255 and holds; frame contents stay the first snapshot.
4. Event in the last STOP cycle -> Dropped +1, no new frame. Event one cycle later -> new frame starts, Tx=0 on the following cycle.
5. Enable=0 mid-frame -> frame completes, Busy drops. Later events -> no frame, Dropped unchanged.
6. Reset pulse during DATA bit 3 of byte 6 -> Tx=1 and Busy=0 asynchronously. After release, next event sends a complete fresh frame starting with A5.
